// File: rtl/smc_seq_ctrl.sv
// Sequential MOSFET ranking controller: serially evaluates six devices (ID or gm),
// insertion-sorts them, and emits the mode-selected average of the top or bottom three.
module smc_seq_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [1:0] mode,
    input  logic [2:0] W,
    input  logic [2:0] V_GS,
    input  logic [2:0] V_DS,
    output logic       out_valid,
    output logic [7:0] out_n,
    output logic       busy
);

    localparam int unsigned DEV_NUM = 6;
    localparam int unsigned VAL_W   = 7;
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned OUT_W   = 8;
    localparam int unsigned SUM_W   = 10;
    localparam int unsigned ARITH_W = 12;
    localparam int unsigned IN_W    = 3;

    localparam logic signed [ARITH_W-1:0] ONE_S   = 1;
    localparam logic signed [ARITH_W-1:0] TWO_S   = 2;
    localparam logic signed [ARITH_W-1:0] THREE_S = 3;
    localparam logic [SUM_W-1:0] K3  = 3;
    localparam logic [SUM_W-1:0] K4  = 4;
    localparam logic [SUM_W-1:0] K5  = 5;
    localparam logic [SUM_W-1:0] K12 = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t                        state_q, state_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [1:0]                    mode_q, mode_d;
    logic [DEV_NUM-1:0][VAL_W-1:0] sort_q, sort_d, sort_ins;
    logic                          out_valid_q, out_valid_d;
    logic [OUT_W-1:0]              out_n_q, out_n_d;
    logic                          busy_q, busy_d;

    logic signed [ARITH_W-1:0]     w_s, vgs_s, vds_s, vov_s, id_s, gm_s;
    logic                          sel_id;
    logic [VAL_W-1:0]              dev_val;
    logic [DEV_NUM-1:0]            ge;
    logic [DEV_NUM-1:0][SUM_W-1:0] ext;
    logic [SUM_W-1:0]              sum;
    logic [OUT_W-1:0]              result;

    // Device evaluator; signed so illegal zero inputs behave arithmetically.
    always_comb begin
        w_s   = $signed({{(ARITH_W-IN_W){1'b0}}, W});
        vgs_s = $signed({{(ARITH_W-IN_W){1'b0}}, V_GS});
        vds_s = $signed({{(ARITH_W-IN_W){1'b0}}, V_DS});
        vov_s = vgs_s - ONE_S;
        if (vov_s > vds_s) begin
            id_s = (w_s * vds_s * (TWO_S * vgs_s - TWO_S - vds_s)) / THREE_S;
            gm_s = (TWO_S * w_s * vds_s) / THREE_S;
        end else begin
            id_s = (w_s * vov_s * vov_s) / THREE_S;
            gm_s = (TWO_S * w_s * vov_s) / THREE_S;
        end
        sel_id  = (state_q == IDLE) ? mode[0] : mode_q[0];
        dev_val = sel_id ? VAL_W'(id_s) : VAL_W'(gm_s);
    end

    // Shift-insert into the descending list; ge is monotone across slots.
    always_comb begin
        for (int i = 0; i < DEV_NUM; i++) begin
            ge[i] = (dev_val >= sort_q[i]);
        end
        sort_ins[0] = ge[0] ? dev_val : sort_q[0];
        for (int i = 1; i < DEV_NUM; i++) begin
            if (!ge[i]) begin
                sort_ins[i] = sort_q[i];
            end else if (ge[i-1]) begin
                sort_ins[i] = sort_q[i-1];
            end else begin
                sort_ins[i] = dev_val;
            end
        end
    end

    // Mode-selected average over the top or bottom three sorted values.
    always_comb begin
        for (int i = 0; i < DEV_NUM; i++) begin
            ext[i] = SUM_W'(sort_q[i]);
        end
        case (mode_q)
            2'b11:   sum = (K3 * ext[0] + K4 * ext[1] + K5 * ext[2]) / K12;
            2'b01:   sum = (K3 * ext[3] + K4 * ext[4] + K5 * ext[5]) / K12;
            2'b10:   sum = (ext[0] + ext[1] + ext[2]) / K3;
            default: sum = (ext[3] + ext[4] + ext[5]) / K3;
        endcase
        result = OUT_W'(sum);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        sort_d      = sort_q;
        out_valid_d = 1'b0;
        out_n_d     = '0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mode_d    = mode;
                    sort_d    = '0;
                    sort_d[0] = dev_val;
                    cnt_d     = CNT_W'(1);
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    sort_d = sort_ins;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DEV_NUM - 1)) begin
                        state_d = CALC;
                    end
                end else begin
                    sort_d  = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            CALC: begin
                out_valid_d = 1'b1;
                out_n_d     = result;
                cnt_d       = '0;
                state_d     = OUT;
            end
            OUT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mode_q      <= '0;
            sort_q      <= '0;
            out_valid_q <= 1'b0;
            out_n_q     <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            sort_q      <= sort_d;
            out_valid_q <= out_valid_d;
            out_n_q     <= out_n_d;
            busy_q      <= busy_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_n     = out_n_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_smc_seq_ctrl.sv
// Bench for smc_seq_ctrl: directed and random frames against a sort-and-average
// reference model computed from device equations.
module tb_smc_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [2:0] W = 3'd0;
    logic [2:0] V_GS = 3'd0;
    logic [2:0] V_DS = 3'd0;
    logic       out_valid;
    logic [7:0] out_n;
    logic       busy;

    int total = 0;
    int bad   = 0;

    int fw[3][6];
    int fg[3][6];
    int fd[3][6];
    int spec_w[6] = '{3, 3, 6, 1, 7, 2};
    int spec_g[6] = '{4, 7, 2, 1, 5, 3};
    int spec_d[6] = '{5, 2, 1, 3, 7, 6};

    always #5 clk = ~clk;

    smc_seq_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .mode      (mode),
        .W         (W),
        .V_GS      (V_GS),
        .V_DS      (V_DS),
        .out_valid (out_valid),
        .out_n     (out_n),
        .busy      (busy)
    );

    function automatic int dev_model(int w, int g, int d, bit sel_id);
        int vov;
        vov = g - 1;
        if (vov > d) return sel_id ? (w * d * (2 * g - 2 - d)) / 3 : (2 * w * d) / 3;
        return sel_id ? (w * vov * vov) / 3 : (2 * w * vov) / 3;
    endfunction

    function automatic int expect_out(int f, logic [1:0] m);
        int q[$];
        for (int i = 0; i < 6; i++) q.push_back(dev_model(fw[f][i], fg[f][i], fd[f][i], m[0]));
        q.rsort();
        case (m)
            2'd3:    return (3 * q[0] + 4 * q[1] + 5 * q[2]) / 12;
            2'd1:    return (3 * q[3] + 4 * q[4] + 5 * q[5]) / 12;
            2'd2:    return (q[0] + q[1] + q[2]) / 3;
            default: return (q[3] + q[4] + q[5]) / 3;
        endcase
    endfunction

    // kind: 0 reference vectors, 1 all sevens, 2 all ones, 3 random legal
    task automatic load_frame(input int f, input int kind);
        for (int i = 0; i < 6; i++) begin
            case (kind)
                0: begin fw[f][i] = spec_w[i]; fg[f][i] = spec_g[i]; fd[f][i] = spec_d[i]; end
                1: begin fw[f][i] = 7; fg[f][i] = 7; fd[f][i] = 7; end
                2: begin fw[f][i] = 1; fg[f][i] = 1; fd[f][i] = 1; end
                default: begin
                    fw[f][i] = $urandom_range(7, 1);
                    fg[f][i] = $urandom_range(7, 1);
                    fd[f][i] = $urandom_range(7, 1);
                end
            endcase
        end
    endtask

    task automatic drive_frame(input int f, input logic [1:0] m, input int n, output int busy_low);
        busy_low = 0;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            mode     = (i == 0) ? m : 2'($urandom);
            W        = 3'(fw[f][i]);
            V_GS     = 3'(fg[f][i]);
            V_DS     = 3'(fd[f][i]);
            @(posedge clk); #1;
            if (busy !== 1'b1) busy_low++;
        end
        in_valid = 1'b0;
        mode     = 2'($urandom);
        W        = 3'($urandom);
        V_GS     = 3'($urandom);
        V_DS     = 3'($urandom);
    endtask

    // Observes five cycles after the last sample; k=2 is the expected pulse cycle.
    task automatic watch(output int first_k, output int pulses, output int val, output int stray,
                         output logic busy_at_out, output logic busy_after);
        first_k = 0; pulses = 0; val = -1; stray = 0; busy_at_out = 1'b0; busy_after = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            if (out_valid === 1'b1) begin
                pulses++;
                if (first_k == 0) begin
                    first_k     = k;
                    val         = int'(out_n);
                    busy_at_out = busy;
                end
            end else if (out_n !== 8'd0) begin
                stray++;
            end
            if (k == 3) busy_after = busy;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        int bl, fk, np, v, st;
        logic bo, ba;
        rst_n = 1'b0; in_valid = 1'b0;
        repeat (2) @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        total++; if (out_n !== 8'd0) begin bad++; $display("FAIL rst_out_n got=%0d exp=0", out_n); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        load_frame(0, 0);
        drive_frame(0, 2'd3, 3, bl);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL midload_busy_before got=%b exp=1", busy); end
        rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midload_busy got=%b exp=0", busy); end
        total++; if (out_valid !== 1'b0 || out_n !== 8'd0) begin
            bad++; $display("FAIL midload_out got_valid=%b got_n=%0d exp=0/0", out_valid, out_n);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        drive_frame(0, 2'd3, 6, bl);
        watch(fk, np, v, st, bo, ba);
        total++; if (v != 19) begin bad++; $display("FAIL post_reset_value got=%0d exp=19", v); end
        total++; if (np != 1) begin bad++; $display("FAIL post_reset_pulses got=%0d exp=1", np); end
    endtask

    task automatic test_all_max();
        int bl, fk, np, v, st, ex;
        logic bo, ba;
        load_frame(0, 1);
        for (int t = 0; t < 2; t++) begin
            ex = (t == 0) ? 84 : 28;
            drive_frame(0, (t == 0) ? 2'd3 : 2'd2, 6, bl);
            watch(fk, np, v, st, bo, ba);
            total++; if (v != ex) begin bad++; $display("FAIL max_value t=%0d got=%0d exp=%0d", t, v, ex); end
            total++; if (fk != 2) begin bad++; $display("FAIL max_latency t=%0d got=%0d exp=2", t, fk); end
        end
    endtask

    task automatic test_spec_vectors();
        int bl, fk, np, v, st;
        int exp_v[4] = '{19, 1, 9, 2};
        logic [1:0] ms[4] = '{2'd3, 2'd1, 2'd2, 2'd0};
        logic bo, ba;
        load_frame(0, 0);
        for (int t = 0; t < 4; t++) begin
            drive_frame(0, ms[t], 6, bl);
            watch(fk, np, v, st, bo, ba);
            total++; if (v != exp_v[t]) begin bad++; $display("FAIL vec_value mode=%0d got=%0d exp=%0d", ms[t], v, exp_v[t]); end
            total++; if (fk != 2 || np != 1) begin bad++; $display("FAIL vec_timing mode=%0d got_k=%0d got_pulses=%0d exp=2/1", ms[t], fk, np); end
            total++; if (st != 0) begin bad++; $display("FAIL vec_out_n_idle mode=%0d got=%0d exp=0", ms[t], st); end
            total++; if (bl != 0 || bo !== 1'b1 || ba !== 1'b0) begin
                bad++; $display("FAIL vec_busy mode=%0d got_low=%0d got_out=%b got_after=%b exp=0/1/0", ms[t], bl, bo, ba);
            end
        end
    endtask

    task automatic test_all_min();
        int bl, fk, np, v, st;
        logic bo, ba;
        load_frame(0, 2);
        for (int m = 0; m < 4; m++) begin
            drive_frame(0, 2'(m), 6, bl);
            watch(fk, np, v, st, bo, ba);
            total++; if (v != 0 || np != 1) begin bad++; $display("FAIL min mode=%0d got=%0d got_pulses=%0d exp=0/1", m, v, np); end
        end
    endtask

    task automatic test_abort();
        int bl, fk, np, v, st;
        logic bo, ba;
        load_frame(0, 0);
        drive_frame(0, 2'd3, 4, bl);
        watch(fk, np, v, st, bo, ba);
        total++; if (np != 0) begin bad++; $display("FAIL abort_pulses got=%0d exp=0", np); end
        total++; if (ba !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", ba); end
        drive_frame(0, 2'd3, 6, bl);
        watch(fk, np, v, st, bo, ba);
        total++; if (v != 19 || fk != 2) begin bad++; $display("FAIL abort_next got=%0d got_k=%0d exp=19/2", v, fk); end
    endtask

    task automatic test_random();
        int bl, fk, np, v, st, ex;
        logic [1:0] m;
        logic bo, ba;
        for (int t = 0; t < 12; t++) begin
            load_frame(0, 3);
            m  = 2'($urandom);
            ex = expect_out(0, m);
            drive_frame(0, m, 6, bl);
            watch(fk, np, v, st, bo, ba);
            total++; if (v != ex || fk != 2 || np != 1) begin
                bad++; $display("FAIL rand t=%0d mode=%0d got=%0d got_k=%0d exp=%0d/2", t, m, v, fk, ex);
            end
        end
    endtask

    // Three frames with no gap; in_valid stays high through CALC/OUT with junk.
    task automatic test_back_to_back();
        int ms[3];
        int ex[3];
        logic exp_valid;
        for (int f = 0; f < 3; f++) begin
            load_frame(f, 3);
            ms[f] = $urandom_range(3, 0);
            ex[f] = expect_out(f, 2'(ms[f]));
        end
        for (int j = 0; j < 26; j++) begin
            int f, k;
            f = j / 8;
            k = j % 8;
            if (j < 22) begin
                in_valid = 1'b1;
                if (k < 6) begin
                    mode = (k == 0) ? 2'(ms[f]) : 2'($urandom);
                    W    = 3'(fw[f][k]);
                    V_GS = 3'(fg[f][k]);
                    V_DS = 3'(fd[f][k]);
                end else begin
                    mode = 2'($urandom);
                    W    = 3'($urandom_range(7, 1));
                    V_GS = 3'($urandom_range(7, 1));
                    V_DS = 3'($urandom_range(7, 1));
                end
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            exp_valid = (k == 6) && (j < 24);
            total++; if (out_valid !== exp_valid) begin
                bad++; $display("FAIL b2b_valid j=%0d got=%b exp=%b", j, out_valid, exp_valid);
            end
            if (exp_valid) begin
                total++; if (int'(out_n) != ex[f]) begin
                    bad++; $display("FAIL b2b_value frame=%0d got=%0d exp=%0d", f, out_n, ex[f]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_all_max();
        test_spec_vectors();
        test_all_min();
        test_abort();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
